// File: rtl/vector_cache_pkg.sv
// rtl/vector_cache_pkg.sv - shared vector-cache types and constants for the write-response path
package vector_cache_pkg;

    localparam int WR_RESP_DIR_NUM  = 4;
    localparam int WR_RESP_DIR_ID_W = 3;
    localparam int WR_RESP_TAG_W    = 5;
    localparam int WR_RESP_SB_W     = 8;

    typedef struct packed {
        logic [WR_RESP_DIR_ID_W-1:0] direction_id;
        logic [WR_RESP_TAG_W-1:0]    tag;
    } wr_resp_txn_id_t;

    typedef struct packed {
        wr_resp_txn_id_t          txn_id;
        logic [WR_RESP_SB_W-1:0]  sideband;
    } wr_resp_pld_t;

    // Increment with wrap at n; used for round-robin pointer advance.
    function automatic int wr_resp_wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/vec_cache_wr_resp_dir_fifo.sv
// rtl/vec_cache_wr_resp_dir_fifo.sv - single-direction write-response FIFO with occupancy count
module vec_cache_wr_resp_dir_fifo
    import vector_cache_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wr_resp_pld_t      push_pld,
    output logic              can_push,
    input  logic              pop_rdy,
    output logic              out_vld,
    output wr_resp_pld_t      out_pld,
    output logic [CNT_W-1:0]  cnt
);

    wr_resp_pld_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     pop;

    assign out_vld  = (cnt != '0);
    assign out_pld  = mem[rd_ptr];
    assign pop      = out_vld && pop_rdy;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign can_push = (cnt != CNT_W'(DEPTH)) || pop;

    // Storage, pointers and occupancy; storage clears so the output payload reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_pld;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vec_cache_wr_resp_arbiter.sv
// rtl/vec_cache_wr_resp_arbiter.sv - routes write responses from N_SRC sources to per-direction FIFOs
module vec_cache_wr_resp_arbiter
    import vector_cache_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int WIDTH = WR_RESP_DIR_NUM,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_SRC-1:0]                v_src_vld,
    input  wr_resp_pld_t [N_SRC-1:0]        v_src_pld,
    output logic [N_SRC-1:0]                v_src_rdy,
    output logic [WIDTH-1:0]                v_wresp_vld,
    output wr_resp_pld_t [WIDTH-1:0]        v_wresp_pld,
    input  logic [WIDTH-1:0]                v_wresp_rdy,
    output logic [WIDTH-1:0][CNT_W-1:0]     v_fifo_cnt,
    output logic                            dir_err
);

    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [WIDTH-1:0][N_SRC-1:0] gnt_m;
    logic [N_SRC-1:0]            illegal;

    // Sources whose direction_id has no port are accepted and dropped.
    always_comb begin
        illegal = '0;
        for (int s = 0; s < N_SRC; s++) begin
            illegal[s] = v_src_vld[s] && (int'(v_src_pld[s].txn_id.direction_id) >= WIDTH);
        end
    end

    // Source ready: granted by its direction or dropped as illegal; held low during reset.
    always_comb begin
        v_src_rdy = '0;
        for (int s = 0; s < N_SRC; s++) begin
            logic r;
            r = illegal[s];
            for (int d = 0; d < WIDTH; d++) begin
                r = r | gnt_m[d][s];
            end
            v_src_rdy[s] = r && !rst;
        end
    end

    // One pulse per cycle regardless of how many sources were dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_err <= 1'b0;
        end else begin
            dir_err <= |illegal;
        end
    end

    for (genvar d = 0; d < WIDTH; d++) begin : g_dir
        logic [N_SRC-1:0] req;
        logic [N_SRC-1:0] gnt;
        logic [SRC_W-1:0] rr_ptr;
        logic [SRC_W-1:0] rr_ptr_nxt;
        logic             can_push;
        logic             found;
        int               idx;
        wr_resp_pld_t     push_pld;

        // Sources currently requesting this direction.
        always_comb begin
            req = '0;
            for (int s = 0; s < N_SRC; s++) begin
                req[s] = v_src_vld[s] && (int'(v_src_pld[s].txn_id.direction_id) == d);
            end
        end

        // Round-robin: first requester at or after rr_ptr, only when the FIFO can take it.
        always_comb begin
            gnt        = '0;
            rr_ptr_nxt = rr_ptr;
            found      = 1'b0;
            idx        = 0;
            for (int i = 0; i < N_SRC; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= N_SRC) begin
                    idx = idx - N_SRC;
                end
                if (!found && can_push && req[idx[SRC_W-1:0]]) begin
                    found                  = 1'b1;
                    gnt[idx[SRC_W-1:0]]    = 1'b1;
                    rr_ptr_nxt             = SRC_W'(wr_resp_wrap_inc(idx, N_SRC));
                end
            end
        end

        // Payload of the (one-hot) granted source.
        always_comb begin
            push_pld = '0;
            for (int s = 0; s < N_SRC; s++) begin
                if (gnt[s]) begin
                    push_pld = v_src_pld[s];
                end
            end
        end

        // Pointer moves past the winner; holds when nothing is granted.
        always_ff @(posedge clk) begin
            if (rst) begin
                rr_ptr <= '0;
            end else if (|gnt) begin
                rr_ptr <= rr_ptr_nxt;
            end
        end

        assign gnt_m[d] = gnt;

        vec_cache_wr_resp_dir_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (|gnt),
            .push_pld (push_pld),
            .can_push (can_push),
            .pop_rdy  (v_wresp_rdy[d]),
            .out_vld  (v_wresp_vld[d]),
            .out_pld  (v_wresp_pld[d]),
            .cnt      (v_fifo_cnt[d])
        );
    end

endmodule

// File: doc/vec_cache_wr_resp_arbiter.md
Name: vec_cache_wr_resp_arbiter

Overview:
- Collects write responses from N_SRC write-completion sources (bank write pipelines) and routes each one by txn_id.direction_id to one of WIDTH direction ports.
- Each direction has its own FIFO. A per-direction round-robin arbiter picks one source per cycle.
- Sits between the bank write pipelines and the direction response channels, and provides backpressure on both sides.

Parameters:
- N_SRC, 4, number of write-response sources.
- WIDTH, 4, number of directions; direction_id values 0..WIDTH-1 are valid.
- DEPTH, 4, entries per direction FIFO; power of two, at least 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- v_src_vld  in  N_SRC  source response valid.
- v_src_pld  in  wr_resp_pld_t[N_SRC]  source response (txn_id, sideband).
- v_src_rdy  out  N_SRC  source response accepted.
- v_wresp_vld  out  WIDTH  direction response valid.
- v_wresp_pld  out  wr_resp_pld_t[WIDTH]  direction response.
- v_wresp_rdy  in  WIDTH  direction consumer ready.
- v_fifo_cnt  out  WIDTH x $clog2(DEPTH+1)  per-direction occupancy, for debug and perf.
- dir_err  out  1  one-cycle pulse when an out-of-range direction_id is accepted.

Behaviour:
- Handshake: a transfer occurs when vld and rdy are both high. A source holds vld/pld stable until rdy. v_src_rdy may depend combinationally on v_src_vld and pld; v_wresp_vld must not depend on v_wresp_rdy.
- Request decode: source s requests direction d when v_src_vld[s] is high and v_src_pld[s].txn_id.direction_id equals d.
- Arbitration, per direction d, each cycle:
  - Candidates are the sources requesting d.
  - Direction d may push when cnt_d < DEPTH, or when cnt_d == DEPTH and its head pops in the same cycle.
  - If d may push, grant the first candidate at or after ptr_d, wrapping modulo N_SRC.
  - At most one grant per direction per cycle. Different directions grant independently in the same cycle.
- v_src_rdy[s] is high when source s is granted by its direction.
- Round-robin pointer: on a grant to source s, ptr_d becomes (s+1) mod N_SRC. With no grant, ptr_d holds. A lone requester is granted every cycle while space exists.
- Illegal direction: if direction_id >= WIDTH, v_src_rdy[s] goes high immediately, the response is dropped, and dir_err pulses in the following cycle. When several sources are illegal in the same cycle, all are dropped and one pulse is produced.
- FIFO, per direction:
  - Push stores the granted pld at wr_ptr. The pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - Pop happens when v_wresp_vld[d] and v_wresp_rdy[d] are both high.
  - cnt_d increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - v_wresp_vld[d] equals (cnt_d != 0). v_wresp_pld[d] equals mem_d[rd_ptr].
- Latency: a response accepted in cycle T appears on v_wresp_vld in cycle T+1 if its FIFO was empty. There is no combinational path from src to wresp.
- Ordering: responses to the same direction are delivered in grant order. There is no ordering guarantee across directions.
- Full, with pop in the same cycle: push is allowed and cnt stays at DEPTH.
- Empty with push: the output is visible the next cycle; there is no bypass.
- Reset, including mid-operation:
  - All FIFO pointers and counts go to 0 and all ptr_d go to 0.
  - Storage clears to 0, so v_wresp_pld is 0 after reset.
  - v_wresp_vld and dir_err go to 0.
  - Pending responses are discarded. While rst is high, v_src_rdy is 0.

Decomposition:
- Additions to vector_cache_pkg:
  - WR_RESP_DIR_NUM = 4.
  - The direction_id width constant.
  - wr_resp_pld_t, which is existing and reused unchanged.
- Sub-module vec_cache_wr_resp_dir_fifo: one-direction FIFO with push/full/pop/cnt, instantiated WIDTH times.
- The round-robin grant logic stays inline in a generate loop over directions.

Test Plan:
- Single source: src0 sends direction_id=2 with sideband=0x5A, all rdy high → v_src_rdy[0]=1 in cycle T, v_wresp_vld[2]=1 with sideband 0x5A in T+1, other directions stay 0.
- Contention: sources 0-3 all target direction 1 and hold vld, v_wresp_rdy[1]=1 → grants in order 0,1,2,3, then 0 again; each source is granted once per 4 cycles.
- Backpressure: v_wresp_rdy[3]=0, src1 streams to direction 3 → 4 accepts, then v_src_rdy[1]=0 with cnt=4. Raising rdy pops and pushes in the same cycle, cnt stays 4, and FIFO order is preserved.
- Parallel directions: src0 to direction 0 and src1 to direction 3 in the same cycle → both rdy=1 and both outputs valid in the next cycle.
- Illegal id: with WIDTH=4, a response carries direction_id=5 → v_src_rdy=1, dir_err=1 one cycle later, and no v_wresp_vld.
- Reset mid-traffic: assert rst with 3 entries queued in direction 0 → next cycle v_wresp_vld=0, cnt=0, pld=0, and the round-robin restarts granting source 0 first.
